// File: rtl/accum_bank_if.sv
// accum_bank_if: sample input, control and drain-output bundle for accum_bank.
interface accum_bank_if #(
  parameter int WIDTH = 4,
  parameter int ACC_WIDTH = 8,
  parameter int CHANNELS = 4
);
  localparam int CW = $clog2(CHANNELS);
  logic [WIDTH-1:0] data;
  logic data_valid;
  logic [CW-1:0] channel;
  logic clear;
  logic dump;
  logic busy;
  logic [ACC_WIDTH-1:0] reg_sum;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CW-1:0] out_channel;
  logic out_overflow;
  logic out_valid;
  logic out_ready;
  modport master (
    output data, data_valid, channel, clear, dump, out_ready,
    input  busy, reg_sum, sum, out_data, out_channel, out_overflow, out_valid
  );
  modport slave (
    input  data, data_valid, channel, clear, dump, out_ready,
    output busy, reg_sum, sum, out_data, out_channel, out_overflow, out_valid
  );
endinterface

// File: rtl/accum_bank.sv
// accum_bank: CHANNELS wrap/saturate accumulators with sticky overflow and a
// valid/ready drain that streams and clears every channel in order.
module accum_bank #(
  parameter int WIDTH = 4,
  parameter int ACC_WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input logic clk_i,
  input logic rst_i,
  accum_bank_if.slave bus
);
  localparam int CW = $clog2(CHANNELS);
  typedef enum logic {IDLE, DRAIN} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [ACC_WIDTH:0] raw;
  logic carry;
  logic [ACC_WIDTH-1:0] next_sum;
  logic busy;
  assign raw = {1'b0, acc_q[bus.channel]} + (ACC_WIDTH+1)'(bus.data);
  assign carry = raw[ACC_WIDTH];
  assign next_sum = (SATURATE != 0 && carry) ? '1 : raw[ACC_WIDTH-1:0];
  assign busy = (state_q == DRAIN);
  assign bus.busy = busy;
  assign bus.out_valid = busy;
  assign bus.out_data = busy ? acc_q[idx_q] : '0;
  assign bus.out_channel = busy ? idx_q : '0;
  assign bus.out_overflow = busy & ovf_q[idx_q];
  assign bus.reg_sum = acc_q[bus.channel];
  assign bus.sum = next_sum;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (bus.clear) begin
      state_d = IDLE;
      idx_d = '0;
      acc_d = '{default: '0};
      ovf_d = '0;
    end else if (state_q == IDLE) begin
      if (bus.data_valid) begin
        acc_d[bus.channel] = next_sum;
        ovf_d[bus.channel] = ovf_q[bus.channel] | carry;
      end
      if (bus.dump) begin
        state_d = DRAIN;
        idx_d = '0;
      end
    end else if (bus.out_ready) begin
      acc_d[idx_q] = '0;
      ovf_d[idx_q] = 1'b0;
      // CHANNELS is a power of two, so the index wraps back to 0 on the last word
      idx_d = idx_q + CW'(1);
      state_d = (idx_q == CW'(CHANNELS - 1)) ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '{default: '0};
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank: wrap and saturate banks driven in lockstep, checked against a
// queue-based drain model.
module tb_accum_bank;
  localparam int W = 4, AW = 8, N = 4, MAXV = 255;
  typedef struct {int c; int v; bit o;} word_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [W-1:0] data = 0;
  logic dv = 0, clr = 0, dump = 0, rdy = 0;
  logic [1:0] ch = 0;
  int total = 0, bad = 0;
  int m_acc [2][N];
  bit m_ovf [2][N];
  word_t mq [2][$];
  accum_bank_if #(.WIDTH(W), .ACC_WIDTH(AW), .CHANNELS(N)) bw ();
  accum_bank_if #(.WIDTH(W), .ACC_WIDTH(AW), .CHANNELS(N)) bs ();
  assign bw.data = data;
  assign bw.data_valid = dv;
  assign bw.channel = ch;
  assign bw.clear = clr;
  assign bw.dump = dump;
  assign bw.out_ready = rdy;
  assign bs.data = data;
  assign bs.data_valid = dv;
  assign bs.channel = ch;
  assign bs.clear = clr;
  assign bs.dump = dump;
  assign bs.out_ready = rdy;
  accum_bank #(.WIDTH(W), .ACC_WIDTH(AW), .CHANNELS(N), .SATURATE(0)) dut_w (.clk_i(clk), .rst_i(rst), .bus(bw));
  accum_bank #(.WIDTH(W), .ACC_WIDTH(AW), .CHANNELS(N), .SATURATE(1)) dut_s (.clk_i(clk), .rst_i(rst), .bus(bs));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int add_res(int s, int a, int d);
    int t = a + d;
    return t > MAXV ? (s == 1 ? MAXV : t - MAXV - 1) : t;
  endfunction
  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < N; c++) begin
        m_acc[s][c] = 0;
        m_ovf[s][c] = 0;
      end
      mq[s].delete();
    end
  endtask
  task automatic model_step();
    word_t w;
    if (rst || clr) begin
      reset_model();
      return;
    end
    for (int s = 0; s < 2; s++) begin
      if (mq[s].size() == 0) begin
        if (dv) begin
          if (m_acc[s][ch] + int'(data) > MAXV) m_ovf[s][ch] = 1;
          m_acc[s][ch] = add_res(s, m_acc[s][ch], int'(data));
        end
        if (dump)
          for (int c = 0; c < N; c++) begin
            w.c = c;
            w.v = m_acc[s][c];
            w.o = m_ovf[s][c];
            mq[s].push_back(w);
          end
      end else if (rdy) begin
        m_acc[s][mq[s][0].c] = 0;
        m_ovf[s][mq[s][0].c] = 0;
        void'(mq[s].pop_front());
      end
    end
  endtask
  task automatic check_one(input int s, input logic b, input logic ov, input logic [AW-1:0] od,
                           input logic [1:0] oc, input logic oo, input logic [AW-1:0] rs, input logic [AW-1:0] sm);
    bit e_b = mq[s].size() != 0;
    string p = s == 0 ? "w" : "s";
    chk({p, "_busy"}, b, e_b);
    chk({p, "_out_valid"}, ov, e_b);
    chk({p, "_out_data"}, od, e_b ? mq[s][0].v : 0);
    chk({p, "_out_channel"}, oc, e_b ? mq[s][0].c : 0);
    chk({p, "_out_overflow"}, oo, e_b ? mq[s][0].o : 0);
    chk({p, "_reg_sum"}, rs, m_acc[s][ch]);
    chk({p, "_sum"}, sm, add_res(s, m_acc[s][ch], int'(data)));
  endtask
  task automatic check_all();
    check_one(0, bw.busy, bw.out_valid, bw.out_data, bw.out_channel, bw.out_overflow, bw.reg_sum, bw.sum);
    check_one(1, bs.busy, bs.out_valid, bs.out_data, bs.out_channel, bs.out_overflow, bs.reg_sum, bs.sum);
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic feed(input int c, input int d);
    ch = 2'(c);
    data = W'(d);
    dv = 1;
    cycle();
    dv = 0;
  endtask
  task automatic all_zero(input string tag);
    for (int c = 0; c < N; c++) begin
      ch = 2'(c);
      #1;
      chk({tag, "_w"}, bw.reg_sum, 0);
      chk({tag, "_s"}, bs.reg_sum, 0);
    end
  endtask
  task automatic drain_all();
    dump = 1;
    cycle();
    dump = 0;
    rdy = 1;
    repeat (N) cycle();
    rdy = 0;
    chk("drain_done_busy", bw.busy, 0);
  endtask
  task automatic load_random();
    for (int c = 0; c < N; c++) feed(c, int'($urandom_range(1, 15)));
  endtask
  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int exp_d [4] = '{3, 5, 0, 9};
    int k;
    reset_model();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
    all_zero("reset_regsum");
    // wrap vs saturate on channel 1
    repeat (17) feed(1, 15);
    chk("w_at_255", bw.reg_sum, 255);
    chk("s_at_255", bs.reg_sum, 255);
    feed(1, 15);
    chk("w_wrapped", bw.reg_sum, 14);
    chk("s_clamped", bs.reg_sum, 255);
    feed(1, 1);
    chk("s_held", bs.reg_sum, 255);
    for (int c = 0; c < N; c += 2) begin
      ch = 2'(c);
      #1;
      chk("other_ch_w", bw.reg_sum, 0);
      chk("other_ch_s", bs.reg_sum, 0);
    end
    ch = 3;
    #1;
    chk("ch3_w", bw.reg_sum, 0);
    dump = 1;
    cycle();
    dump = 0;
    rdy = 1;
    cycle();
    chk("w_ovf1", bw.out_overflow, 1);
    chk("s_ovf1", bs.out_overflow, 1);
    repeat (N - 1) cycle();
    rdy = 0;
    // drain with backpressure
    feed(0, 3);
    feed(1, 5);
    feed(3, 9);
    dump = 1;
    cycle();
    dump = 0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      rdy = pat[i][0];
      if (rdy) begin
        chk("bp_chan", bw.out_channel, k);
        chk("bp_data", bw.out_data, exp_d[k]);
        k++;
      end
      cycle();
    end
    rdy = 0;
    chk("bp_busy", bw.busy, 0);
    all_zero("bp_cleared");
    // sample accepted in the Dump cycle is part of the drain
    feed(2, 4);
    ch = 2;
    data = 6;
    dv = 1;
    dump = 1;
    cycle();
    dump = 0;
    rdy = 1;
    for (int i = 0; i < N; i++) begin
      if (i == 2) chk("dump_same_cycle", bw.out_data, 10);
      data = W'($urandom);
      ch = 2'($urandom);
      cycle();
    end
    dv = 0;
    rdy = 0;
    all_zero("dv_in_drain");
    // Clear wins over Dump
    feed(0, 7);
    feed(3, 2);
    clr = 1;
    dump = 1;
    cycle();
    clr = 0;
    dump = 0;
    chk("clr_dump_busy", bw.busy, 0);
    all_zero("clr_dump");
    // asynchronous reset mid-drain
    load_random();
    dump = 1;
    cycle();
    dump = 0;
    rdy = 1;
    repeat (2) cycle();
    rdy = 0;
    #3;
    rst = 1;
    #1;
    reset_model();
    chk("async_rst_valid", bw.out_valid, 0);
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
    all_zero("after_rst");
    // Clear aborts a drain
    load_random();
    dump = 1;
    cycle();
    dump = 0;
    rdy = 1;
    repeat (2) cycle();
    clr = 1;
    cycle();
    clr = 0;
    rdy = 0;
    chk("clr_abort_valid", bw.out_valid, 0);
    all_zero("clr_abort");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      dv = 1'($urandom);
      ch = 2'($urandom);
      data = W'($urandom);
      clr = ($urandom % 40) == 0;
      dump = ($urandom % 8) == 0;
      rdy = 1'($urandom);
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
